computer_player: RTL and testbench
==================================

// Module: computer_player
// PURPOSE
//  Computer opponent for tug-of-war. Emits pseudo-random "button presses" in place of a human player.
//  level mimics a held KEY (active-high = pressed).
//  out is a one-cycle pulse on each release, timed exactly like the user-input edge detector's
//   output, so either source drives the game logic interchangeably.
//  Press probability per opportunity is set by difficulty, compared against an internal LFSR.
// PARAMETERS
//  LFSR_W       10  LFSR and difficulty width
//  PRESS_CYCLES 4   cycles level is held high per press (>=1)
//  GAP_CYCLES   8   minimum cycles level is low after a press (>=1)
//  TICK_DIV     1   one press opportunity every TICK_DIV cycles (>=1)
// PORTS
//  Clock      in  1       system clock, all logic on posedge
//  Reset      in  1       synchronous, active-high
//  enable     in  1       1 = player may start new presses
//  difficulty in  LFSR_W  press when lfsr < difficulty (0 = never)
//  level      out 1       emulated held key, 1 = pressed
//  out        out 1       one-cycle pulse on release (first cycle level is 0 after a press)
//  busy       out 1       1 when state != IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, lfsr=0, tick_cnt=0, cnt=0; level=0, out=0, busy=0.
//   Reset wins over every other input; applies mid-press at the next edge.
//   No out pulse is generated by a reset.
//  LFSR: fb = ~(lfsr[9] ^ lfsr[6]) (XNOR, x^10+x^7+1), lfsr <= {lfsr[8:0], fb}.
//   Advances every non-reset cycle, independent of enable and state.
//   Sequence from reset: 0, 1, 3, 7, 15, ... All-ones is the lockup state and is unreachable.
//  tick_cnt: counts 0..TICK_DIV-1 and wraps, free-running.
//   tick = (tick_cnt == TICK_DIV-1); with TICK_DIV=1, tick is always 1.
//  Comparison is unsigned, LFSR_W bits, against the current (pre-advance) lfsr value.
//  FSM (cnt is a down-counter wide enough for max(PRESS_CYCLES, GAP_CYCLES)):
//   IDLE: level=0.
//    tick & enable & (lfsr < difficulty) -> HOLD, cnt <= PRESS_CYCLES-1.
//    Otherwise stay in IDLE.
//   HOLD: level=1. cnt==0 -> GAP, cnt <= GAP_CYCLES-1; else cnt--.
//    enable and difficulty are ignored; a started press always runs its full length.
//   GAP: level=0. cnt==0 -> IDLE; else cnt--. enable and difficulty are ignored.
//  out = (state==GAP) & (cnt==GAP_CYCLES-1), decoded from registers.
//   Exactly one pulse per press, in the first cycle of GAP.
//  level and busy are decoded from registered state only; no input-to-output combinational path.
//  Latency: the decision is made in the IDLE cycle; level rises in the following cycle.
//  Minimum press period is 1+PRESS_CYCLES+GAP_CYCLES cycles (13 with defaults, TICK_DIV=1).
//  Boundaries:
//   difficulty=0 never presses.
//   difficulty=2^LFSR_W-1 presses at every opportunity (lfsr never reaches all-ones).
//   enable dropped during GAP: returns to IDLE and stays there.
// TESTING
//  1 Reset 2 cycles, then release, enable=0.
//    -> level=0, out=0, busy=0 every cycle.
//    -> lfsr reads 0, 1, 3, 7, 15 on the first 5 post-reset cycles.
//  2 difficulty=1023, enable=1, defaults.
//    -> level=1 on cycles 1-4 after reset release, out=1 on cycle 5 only.
//    -> next level rise on cycle 14; period 13, sustained for 100 periods.
//  3 difficulty=0, enable=1, 2000 cycles.
//    -> level, out and busy stay 0 throughout.
//  4 difficulty=1023, enable dropped on the 2nd HOLD cycle.
//    -> level still high 4 cycles, one out pulse, 8 GAP cycles, then IDLE with busy=0 indefinitely.
//  5 Reset asserted on the 3rd HOLD cycle.
//    -> next cycle level=0, busy=0, no out pulse; lfsr restarts at 0.
//  6 level fed into the user-input edge detector, difficulty=512, 10230 cycles.
//    -> detector's out equals this block's out every cycle.
//    -> pulse count matches a cycle-accurate reference model.

Source files
------------

// File: rtl/computer_player.sv
// computer_player: pseudo-random tug-of-war opponent emitting held-key presses and release pulses
// Ports: clk_i/rst_i clock and sync active-high reset; enable_i allows new presses;
//        difficulty_i press threshold (press when lfsr < difficulty); level_o emulated key;
//        out_o one-cycle release pulse; busy_o high while a press or its gap is in progress.
module computer_player #(
  parameter int LFSR_W       = 10,
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 8,
  parameter int TICK_DIV     = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [LFSR_W-1:0] difficulty_i,
  output logic              level_o,
  output logic              out_o,
  output logic              busy_o
);
  localparam int MAX_C  = PRESS_CYCLES > GAP_CYCLES ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C + 1);
  localparam int TICK_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                tick, press;
  always_comb begin
    tick       = tick_cnt_q == TICK_W'(TICK_DIV - 1);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    // XNOR feedback keeps the all-zero reset value legal; all-ones is the unreachable lockup
    lfsr_d     = {lfsr_q[LFSR_W-2:0], ~(lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-4])};
    press      = tick & enable_i & (lfsr_q < difficulty_i);
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (state_q == IDLE && press) begin
      state_d = HOLD;
      cnt_d   = CNT_W'(PRESS_CYCLES - 1);
    end else if (state_q == HOLD) begin
      state_d = cnt_q == '0 ? GAP : HOLD;
      cnt_d   = cnt_q == '0 ? CNT_W'(GAP_CYCLES - 1) : cnt_q - 1'b1;
    end else if (state_q == GAP) begin
      state_d = cnt_q == '0 ? IDLE : GAP;
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lfsr_q     <= '0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end
  // release pulse lands in the first GAP cycle, matching an edge detector on level_o
  assign level_o = state_q == HOLD;
  assign out_o   = state_q == GAP && cnt_q == CNT_W'(GAP_CYCLES - 1);
  assign busy_o  = state_q != IDLE;
endmodule

// File: tb/tb_computer_player.sv
// tb_computer_player: randomized self-checking bench for computer_player against a press-timer model
module tb_computer_player;
  localparam int P = 4, G = 8, TD = 1;
  logic clk = 0, rst = 1, en = 0;
  logic [9:0] diff = '0;
  logic level, out, busy;
  int checks = 0, failures = 0;
  int m_t = 0, m_lfsr = 0, m_tc = 0, m_pulses = 0;

  computer_player dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .difficulty_i(diff),
    .level_o(level), .out_o(out), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // model: m_t counts cycles left in the current press+gap, 0 means idle
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_lfsr = 0; m_tc = 0;
    end else begin
      if (m_t == 0 && m_tc == TD - 1 && en && m_lfsr < int'(diff)) m_t = P + G;
      else if (m_t > 0) m_t = m_t - 1;
      m_lfsr = ((m_lfsr << 1) & 1023) | ((~((m_lfsr >> 9) ^ (m_lfsr >> 6))) & 1);
      m_tc = (m_tc + 1) % TD;
    end
    if (m_t == G) m_pulses++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) step();
    rst = 0;
  endtask

  task automatic test_reset();
    int seq[5] = '{0, 1, 3, 7, 15};
    en = 0; diff = 10'd1023;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({level, out, busy} !== 3'b000 || dut.lfsr_q !== 10'd0) begin
        failures++; $display("FAIL reset_hold lvl/out/busy=%b lfsr=%0d want 000 lfsr=0", {level, out, busy}, dut.lfsr_q);
      end
    end
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (int'(dut.lfsr_q) !== seq[i] || {level, out, busy} !== 3'b000) begin
        failures++; $display("FAIL lfsr_seq[%0d] got lfsr=%0d lob=%b want lfsr=%0d lob=000", i, dut.lfsr_q, {level, out, busy}, seq[i]);
      end
      step();
    end
  endtask

  task automatic test_full_rate();
    diff = 10'd1023; en = 1;
    do_reset(2);
    for (int k = 1; k <= 1300; k++) begin
      step();
      checks++;
      if (level !== (((k - 1) % 13) < P) || out !== (((k - 1) % 13) == P) ||
          {level, out, busy} !== {m_t > G, m_t == G, m_t > 0}) begin
        failures++; $display("FAIL full_rate k=%0d lob=%b want level=%0d out=%0d", k, {level, out, busy}, ((k - 1) % 13) < P, ((k - 1) % 13) == P);
      end
    end
  endtask

  task automatic test_never();
    diff = 10'd0; en = 1;
    do_reset(2);
    for (int k = 0; k < 2000; k++) begin
      step();
      checks++;
      if ({level, out, busy} !== 3'b000) begin
        failures++; $display("FAIL never k=%0d lob=%b want 000", k, {level, out, busy});
      end
    end
  endtask

  task automatic test_enable_drop();
    diff = 10'd1023; en = 1;
    do_reset(2);
    step(); step();
    en = 0;
    checks++;
    if (level !== 1'b1) begin
      failures++; $display("FAIL drop_hold2 level=%b want 1", level);
    end
    for (int k = 3; k <= 60; k++) begin
      step();
      checks++;
      if ({level, out, busy} !== {k <= P, k == P + 1, k <= P + G} ||
          {level, out, busy} !== {m_t > G, m_t == G, m_t > 0}) begin
        failures++; $display("FAIL enable_drop k=%0d lob=%b want %b", k, {level, out, busy}, {k <= P, k == P + 1, k <= P + G});
      end
    end
  endtask

  task automatic test_reset_mid_press();
    diff = 10'd1023; en = 1;
    do_reset(2);
    repeat (3) step();
    checks++;
    if (level !== 1'b1) begin
      failures++; $display("FAIL mid_hold3 level=%b want 1", level);
    end
    rst = 1;
    step();
    rst = 0;
    checks++;
    if ({level, out, busy} !== 3'b000 || dut.lfsr_q !== 10'd0) begin
      failures++; $display("FAIL mid_reset lob=%b lfsr=%0d want 000 lfsr=0", {level, out, busy}, dut.lfsr_q);
    end
    en = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out !== 1'b0 || int'(dut.lfsr_q) !== m_lfsr) begin
        failures++; $display("FAIL post_reset i=%0d out=%b lfsr=%0d want out=0 lfsr=%0d", i, out, dut.lfsr_q, m_lfsr);
      end
    end
  endtask

  task automatic test_edge_detector();
    logic prev;
    int dut_pulses = 0;
    diff = 10'd512; en = 1;
    do_reset(2);
    prev = level;
    m_pulses = 0;
    for (int k = 0; k < 10230; k++) begin
      step();
      if (out) dut_pulses++;
      checks++;
      if (out !== (prev & ~level) || {level, out, busy} !== {m_t > G, m_t == G, m_t > 0}) begin
        failures++; $display("FAIL edge_det k=%0d lob=%b det=%b model=%b", k, {level, out, busy}, prev & ~level, {m_t > G, m_t == G, m_t > 0});
      end
      prev = level;
    end
    checks++;
    if (dut_pulses !== m_pulses || dut_pulses == 0) begin
      failures++; $display("FAIL pulse_count got %0d want %0d", dut_pulses, m_pulses);
    end
  endtask

  task automatic test_random();
    do_reset(1);
    for (int k = 0; k < 6000; k++) begin
      if (k % 97 == 0) diff = 10'($urandom_range(0, 1023));
      if (k % 31 == 0) en = 1'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      step();
      checks++;
      if ({level, out, busy} !== {m_t > G, m_t == G, m_t > 0} || int'(dut.lfsr_q) !== m_lfsr) begin
        failures++; $display("FAIL random k=%0d lob=%b lfsr=%0d want %b lfsr=%0d", k, {level, out, busy}, dut.lfsr_q, {m_t > G, m_t == G, m_t > 0}, m_lfsr);
      end
    end
    rst = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_rate();
    test_never();
    test_enable_drop();
    test_reset_mid_press();
    test_edge_detector();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
